// File: rtl/serializer_pkg.sv
// Shared types and sizing helpers for the multilane serializer.
// Sizing functions are evaluated at elaboration time from the WIDTH/LANES parameters.
package serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    function automatic int calc_beats(input int width, input int lanes);
        return width / lanes;
    endfunction

    // A single-beat word still needs a one-bit counter so the port never collapses to zero width.
    function automatic int calc_cnt_width(input int width, input int lanes);
        int beats;
        beats = width / lanes;
        return (beats <= 1) ? 1 : $clog2(beats);
    endfunction

endpackage

// File: rtl/ser_beat_counter.sv
// Modulo-BEATS beat counter with a last-beat flag.
// The counter holds while disabled and wraps to zero after the last beat.
module ser_beat_counter #(
    parameter int BEATS = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_i,
    output logic [CNT_W-1:0] count_o,
    output logic             last_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign last_o  = (count_q == CNT_W'(BEATS - 1));
    assign count_o = count_q;

    // NOTE: always_comb assigns its default first, so no path leaves count_d unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (enable_i) begin
            count_d = last_o ? '0 : count_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multilane_serializer.sv
// Parallel-to-serial converter: one shift register plus a one-deep holding register,
// emitting WIDTH/LANES beats per word with back-to-back streaming.
module multilane_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int LANES     = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_enable,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic [LANES-1:0] serial_data_out,
    output logic             serial_valid,
    output logic             frame_start
);

    localparam int BEATS = calc_beats(WIDTH, LANES);
    localparam int CNT_W = calc_cnt_width(WIDTH, LANES);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic             ready_q;
    logic             accept;
    logic             last_beat;
    logic [CNT_W-1:0] count;
    logic [LANES-1:0] lane_bits;

    ser_beat_counter #(
        .BEATS (BEATS),
        .CNT_W (CNT_W)
    ) u_beat_counter (
        .clk      (clk),
        .reset    (reset),
        .enable_i (state_q == SHIFT),
        .count_o  (count),
        .last_o   (last_beat)
    );

    assign accept = write_enable && ready_q;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d = data_in;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_beat) begin
                    // Word boundary: refill from holding first, then straight from the input, else drain.
                    if (hold_valid_q) begin
                        shift_d      = hold_q;
                        hold_valid_d = 1'b0;
                    end else if (accept) begin
                        shift_d = data_in;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    shift_d = MSB_FIRST ? (shift_q << LANES) : (shift_q >> LANES);
                    if (accept) begin
                        hold_d       = data_in;
                        hold_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            ready_q      <= !hold_valid_d;
        end
    end

    // NOTE: payload registers are not reset; state and the valid flag alone decide whether their contents matter.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        hold_q  <= hold_d;
    end

    always_comb begin
        lane_bits = '0;
        for (int j = 0; j < LANES; j++) begin
            lane_bits[j] = MSB_FIRST ? shift_q[WIDTH-1-j] : shift_q[j];
        end
    end

    assign ready           = ready_q;
    assign serial_valid    = (state_q == SHIFT);
    assign serial_data_out = serial_valid ? lane_bits : '0;
    assign frame_start     = serial_valid && (count == '0);

endmodule

// File: tb/tb_multilane_serializer.sv
// Self-checking bench for multilane_serializer: three parameterisations share one clock and reset,
// each with a scoreboard queue of expected beats popped by a negedge monitor.
module tb_multilane_serializer;

    typedef struct packed {
        logic [3:0] data;
        logic       fs;
    } beat_t;

    typedef struct {
        logic [7:0] data;
        logic [7:0] seq;
    } vec_a_t;

    typedef struct {
        logic [7:0] data;
        logic [3:0] b0;
        logic [3:0] b1;
    } vec_b_t;

    logic clk;
    logic reset;
    logic mon_en;

    logic       we_a, rdy_a, sv_a, fs_a;
    logic [7:0] din_a;
    logic [0:0] sd_a;
    logic       we_b, rdy_b, sv_b, fs_b;
    logic [7:0] din_b;
    logic [3:0] sd_b;
    logic       we_c, rdy_c, sv_c, fs_c;
    logic [3:0] din_c;
    logic [3:0] sd_c;

    beat_t q_a[$];
    beat_t q_b[$];
    beat_t q_c[$];

    int n_checks = 0;
    int n_errors = 0;

    vec_a_t tab_a[5];
    vec_b_t tab_b[3];

    multilane_serializer #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b0)) u_dut_a (
        .clk (clk), .reset (reset), .write_enable (we_a), .data_in (din_a),
        .ready (rdy_a), .serial_data_out (sd_a), .serial_valid (sv_a), .frame_start (fs_a)
    );

    multilane_serializer #(.WIDTH(8), .LANES(4), .MSB_FIRST(1'b1)) u_dut_b (
        .clk (clk), .reset (reset), .write_enable (we_b), .data_in (din_b),
        .ready (rdy_b), .serial_data_out (sd_b), .serial_valid (sv_b), .frame_start (fs_b)
    );

    multilane_serializer #(.WIDTH(4), .LANES(4), .MSB_FIRST(1'b0)) u_dut_c (
        .clk (clk), .reset (reset), .write_enable (we_c), .data_in (din_c),
        .ready (rdy_c), .serial_data_out (sd_c), .serial_valid (sv_c), .frame_start (fs_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a_seq(input logic [7:0] seq);
        for (int k = 0; k < 8; k++) begin
            q_a.push_back('{data: {3'b000, seq[7-k]}, fs: (k == 0)});
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q_a.size() + q_b.size() + q_c.size()) != 0 && n < 40) begin
            cycle();
            n++;
        end
        check({name, "_drain"}, q_a.size() + q_b.size() + q_c.size(), 0);
        cycle();
    endtask

    always @(negedge clk) begin : mon_a
        beat_t e;
        if (mon_en) begin
            if (sv_a) begin
                check("a_beat_expected", q_a.size() != 0, 1);
                if (q_a.size() != 0) begin
                    e = q_a.pop_front();
                    check("a_data", sd_a, e.data);
                    check("a_frame_start", fs_a, e.fs);
                end
            end else begin
                check("a_idle_outputs", {fs_a, sd_a}, 0);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        beat_t e;
        if (mon_en) begin
            if (sv_b) begin
                check("b_beat_expected", q_b.size() != 0, 1);
                if (q_b.size() != 0) begin
                    e = q_b.pop_front();
                    check("b_data", sd_b, e.data);
                    check("b_frame_start", fs_b, e.fs);
                end
            end else begin
                check("b_idle_outputs", {fs_b, sd_b}, 0);
            end
        end
    end

    always @(negedge clk) begin : mon_c
        beat_t e;
        if (mon_en) begin
            if (sv_c) begin
                check("c_beat_expected", q_c.size() != 0, 1);
                if (q_c.size() != 0) begin
                    e = q_c.pop_front();
                    check("c_data", sd_c, e.data);
                    check("c_frame_start", fs_c, e.fs);
                end
            end else begin
                check("c_idle_outputs", {fs_c, sd_c}, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // First-beat-first sequences for LSB-first, one lane.
        tab_a[0] = '{data: 8'hA5, seq: 8'b10100101};
        tab_a[1] = '{data: 8'h0F, seq: 8'b11110000};
        tab_a[2] = '{data: 8'h01, seq: 8'b10000000};
        tab_a[3] = '{data: 8'h80, seq: 8'b00000001};
        tab_a[4] = '{data: 8'h3C, seq: 8'b00111100};
        // MSB-first, four lanes: {lane3..lane0} per beat.
        tab_b[0] = '{data: 8'h3C, b0: 4'b1100, b1: 4'b0011};
        tab_b[1] = '{data: 8'hA5, b0: 4'b0101, b1: 4'b1010};
        tab_b[2] = '{data: 8'h12, b0: 4'b1000, b1: 4'b0100};

        mon_en = 1'b0;
        reset  = 1'b1;
        we_a = 1'b1; din_a = 8'h77;
        we_b = 1'b1; din_b = 8'h77;
        we_c = 1'b1; din_c = 4'h7;
        cycle();
        cycle();
        check("rst_a_outputs", {rdy_a, sv_a, fs_a, sd_a}, 4'b1000);
        check("rst_b_outputs", {rdy_b, sv_b, fs_b, sd_b}, 7'b1000000);
        check("rst_c_outputs", {rdy_c, sv_c, fs_c, sd_c}, 7'b1000000);
        reset = 1'b0;
        we_a = 1'b0; we_b = 1'b0; we_c = 1'b0;
        cycle();
        check("rst_write_ignored_a", {rdy_a, sv_a}, 2'b10);
        check("rst_write_ignored_c", {rdy_c, sv_c}, 2'b10);
        mon_en = 1'b1;
        cycle();

        // Single words on the 8x1 LSB-first instance.
        foreach (tab_a[i]) begin
            check("a_ready_idle", rdy_a, 1);
            din_a = tab_a[i].data;
            we_a  = 1'b1;
            push_a_seq(tab_a[i].seq);
            cycle();
            we_a = 1'b0;
            check("a_first_beat_latency", {sv_a, fs_a}, 2'b11);
            drain("a_table");
        end

        // Single words on the 8x4 MSB-first instance.
        foreach (tab_b[i]) begin
            din_b = tab_b[i].data;
            we_b  = 1'b1;
            q_b.push_back('{data: tab_b[i].b0, fs: 1'b1});
            q_b.push_back('{data: tab_b[i].b1, fs: 1'b0});
            cycle();
            we_b = 1'b0;
            check("b_first_beat", sd_b, tab_b[i].b0);
            cycle();
            check("b_second_beat", sd_b, tab_b[i].b1);
            cycle();
            check("b_done_after_two", sv_b, 0);
            drain("b_table");
        end

        // 0x0F then 0xF0 queued at beat 3, plus a dropped 0x55 while the holding register is full.
        din_a = 8'h0F;
        we_a  = 1'b1;
        push_a_seq(8'b11110000);
        cycle();
        we_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("b2b_valid", sv_a, 1);
            check("b2b_ready_open", rdy_a, 1);
            if (k == 3) begin
                din_a = 8'hF0;
                we_a  = 1'b1;
                push_a_seq(8'b00001111);
            end
            cycle();
            we_a = 1'b0;
        end
        for (int k = 4; k < 16; k++) begin
            check("b2b_valid", sv_a, 1);
            check("b2b_ready", rdy_a, (k < 8) ? 32'd0 : 32'd1);
            if (k == 8) check("b2b_second_frame_start", fs_a, 1);
            if (k == 5) begin
                din_a = 8'h55;
                we_a  = 1'b1;
            end
            cycle();
            we_a = 1'b0;
        end
        check("b2b_end_idle", {sv_a, rdy_a}, 2'b01);
        drain("b2b");

        // Reset at beat 4 of 0xA5 with 0x3C waiting in the holding register.
        din_a = 8'hA5;
        we_a  = 1'b1;
        push_a_seq(8'b10100101);
        cycle();
        we_a = 1'b0;
        cycle();
        din_a = 8'h3C;
        we_a  = 1'b1;
        cycle();
        we_a = 1'b0;
        check("rst_mid_hold_full", rdy_a, 0);
        cycle();
        cycle();
        check("rst_mid_at_beat4", {sv_a, fs_a}, 2'b10);
        reset = 1'b1;
        cycle();
        q_a.delete();
        check("rst_mid_outputs", {rdy_a, sv_a, fs_a, sd_a}, 4'b1000);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            check("rst_mid_no_beats", sv_a, 0);
        end

        // One-beat words on consecutive cycles.
        we_c = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            din_c = 4'(k);
            q_c.push_back('{data: 4'(k), fs: 1'b1});
            cycle();
            check("c_stream_data", sd_c, k);
            check("c_stream_flags", {sv_c, fs_c, rdy_c}, 3'b111);
        end
        for (int k = 0; k < 10; k++) begin
            din_c = 4'($urandom_range(0, 15));
            q_c.push_back('{data: din_c, fs: 1'b1});
            cycle();
        end
        we_c = 1'b0;
        cycle();
        check("c_stream_stop", sv_c, 0);
        drain("c_stream");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multilane_serializer.md
MULTILANE_SERIALIZER -- requirements
Module: multilane_serializer

Interface
REQ-001 Parameter WIDTH, default 32: parallel word width; SHALL be an integer multiple of LANES.
REQ-002 Parameter LANES, default 1: number of parallel serial lanes; BEATS = WIDTH/LANES.
REQ-003 Parameter MSB_FIRST, default 0: 0 sends the word LSB-first, 1 sends it MSB-first.
REQ-004 Port clk, input, 1 bit: single clock; all state SHALL change on the rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port write_enable, input, 1 bit: word write request.
REQ-007 Port data_in, input, WIDTH bits: word to serialize; sampled only on an accepted write.
REQ-008 Port ready, output, 1 bit: block can accept a word this cycle.
REQ-009 Port serial_data_out, output, LANES bits: current beat, one bit per lane.
REQ-010 Port serial_valid, output, 1 bit: serial_data_out carries a valid beat.
REQ-011 Port frame_start, output, 1 bit: current beat is beat 0 of a word.

Function
REQ-012 A write SHALL be accepted when write_enable=1 and ready=1 on the same edge.
REQ-013 A write with ready=0 SHALL be ignored: data dropped, no state change.
REQ-014 Storage SHALL be one shift register plus one holding register with a valid flag.
REQ-015 ready SHALL be registered and equal to NOT(holding valid).
REQ-016 States: IDLE and SHIFT. IDLE->SHIFT on an accepted write. SHIFT->IDLE after the last beat when neither the holding register nor an accepted write supplies a next word.
REQ-017 Latency: a word accepted at edge N from IDLE SHALL present beat 0 in the cycle following edge N.
REQ-018 Beat counter SHALL run 0..BEATS-1 and wrap to 0 at each word boundary.
REQ-019 Lane mapping, MSB_FIRST=0: beat k, lane j SHALL carry data bit k*LANES+j.
REQ-020 Lane mapping, MSB_FIRST=1: beat k, lane j SHALL carry data bit WIDTH-1-(k*LANES+j).
REQ-021 Accepted write in SHIFT before the last beat: word goes to the holding register.
REQ-022 At the last-beat edge, holding valid: the holding word SHALL load into the shifter, the count SHALL reset to 0, and holding valid SHALL clear.
REQ-023 At the last-beat edge, holding empty with an accepted write: data_in SHALL load directly into the shifter, with no gap beat.
REQ-024 Back-to-back words SHALL stream with serial_valid continuously high.
REQ-025 BEATS=1: every accepted write SHALL produce exactly one beat, and a sustained one-word-per-cycle stream SHALL be supported.
REQ-026 frame_start SHALL be 1 only when serial_valid=1 and the count is 0.
REQ-027 When serial_valid=0, serial_data_out SHALL be all zeros.

Reset
REQ-028 Reset SHALL force: state IDLE, count 0, holding valid 0, ready 1, serial_valid 0, frame_start 0, serial_data_out 0.
REQ-029 Reset mid-frame SHALL discard the shifter and holding contents; no remaining beats are emitted.
REQ-030 A write asserted in the same cycle as reset SHALL be ignored.

Structure
REQ-031 Package serializer_pkg SHALL hold the state enum (IDLE, SHIFT) and a function that computes BEATS and the counter width.
REQ-032 Sub-module ser_beat_counter (modulo-BEATS counter with a last-beat flag) SHALL be instantiated once; all other logic lives in the top module.

Verification
REQ-033 WIDTH=8, LANES=1, MSB_FIRST=0, write 0xA5 -> serial bits 1,0,1,0,0,1,0,1 on the next 8 cycles; serial_valid high for those 8 cycles; frame_start high only in the first.
REQ-034 WIDTH=8, LANES=4, MSB_FIRST=1, write 0x3C -> beat 0 = 4'b1100, beat 1 = 4'b0011; serial_valid high for 2 cycles.
REQ-035 WIDTH=8, LANES=1, write 0x0F then 0xF0 at beat 3 -> 16 contiguous valid beats; ready low from the 0xF0 accept until the word boundary; frame_start at beats 0 and 8.
REQ-036 With the holding register full, write 0x55 while ready=0 -> 0x55 never appears on the serial output; the stream is unchanged.
REQ-037 Reset asserted at beat 4 of 0xA5 with a word in the holding register -> next cycle serial_valid=0, ready=1, and no further beats are emitted.
REQ-038 WIDTH=4, LANES=4, writes 0x1, 0x2, 0x3 on consecutive cycles -> serial_data_out 0x1, 0x2, 0x3 on consecutive cycles; frame_start high on each.
